exe_mem_pipe_reg: RTL and testbench

- Parametrised EXE→MEM pipeline register, successor to the fixed-width freeze-only stage register.
- Replaces the global freeze with a valid/ready handshake and adds an optional 2-entry skid buffer, so the upstream ready path is fully registered.
- Adds a synchronous flush that turns in-flight entries into bubbles.
- Sits between the ALU/EXE stage and the data-memory stage; payload = control bits, ALU result, store value, destination register.

---
 rtl/exe_mem_pipe_reg.sv | 90 +++++++++
 tb/tb_exe_mem_pipe_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register: valid/ready handshake, optional two-entry skid
// buffer giving a fully registered in_ready, and a synchronous flush to bubbles.
module exe_mem_pipe_reg #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [DEST_W-1:0] dest,
  output logic [1:0]        occupancy
);

  localparam int PAY_W = CTRL_W + 2 * DATA_W + DEST_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_q, main_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             accept;
  logic             drain;

  assign in_pay   = {ctrl_in, alu_result_in, st_val_in, dest_in};
  assign in_ready = (SKID != 0) ? ~skid_valid_q : (~main_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // A waiting skid entry is older than anything upstream, so it goes first.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_d = in_pay;
        end
      end
    end else if (accept && (SKID != 0)) begin
      skid_d       = in_pay;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Control bits are gated so a bubble can never enable memory or write-back.
  assign out_valid  = main_valid_q;
  assign ctrl       = main_valid_q ? main_q[PAY_W-1 -: CTRL_W] : '0;
  assign alu_result = main_q[DEST_W + 2 * DATA_W - 1 -: DATA_W];
  assign st_val     = main_q[DEST_W + DATA_W - 1 -: DATA_W];
  assign dest       = main_q[DEST_W-1:0];
  assign occupancy  = {main_valid_q & skid_valid_q, main_valid_q ^ skid_valid_q};

endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Bench for exe_mem_pipe_reg: a SKID=1 and a SKID=0 instance share one directed
// stimulus stream; each has its own expected-payload queue checked by a monitor.
module tb_exe_mem_pipe_reg;

  typedef struct packed {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] s;
    logic [3:0]  d;
  } pay_t;

  localparam pay_t ZERO = '0;
  localparam pay_t P1 = {3'b101, 32'h0000_1234, 32'hDEAD_BEEF, 4'hA};
  localparam pay_t P2 = {3'b110, 32'h1111_0001, 32'h0000_0002, 4'h1};
  localparam pay_t P3 = {3'b001, 32'h2222_0003, 32'h0000_0004, 4'h2};
  localparam pay_t P4 = {3'b100, 32'h3333_0005, 32'h0000_0006, 4'h3};
  localparam pay_t PA = {3'b110, 32'hAAAA_0001, 32'h5555_0001, 4'h4};
  localparam pay_t PB = {3'b011, 32'hBBBB_0002, 32'h5555_0002, 4'h5};
  localparam pay_t PC = {3'b100, 32'hCCCC_0003, 32'h5555_0003, 4'h6};
  localparam pay_t PD = {3'b010, 32'hDDDD_0004, 32'h5555_0004, 4'h7};
  localparam pay_t PE = {3'b111, 32'hEEEE_0005, 32'h5555_0005, 4'h8};
  localparam pay_t PF = {3'b101, 32'hFFFF_0006, 32'h5555_0006, 4'h9};
  localparam pay_t PX = {3'b100, 32'h0101_0101, 32'h7777_0001, 4'hB};
  localparam pay_t PY = {3'b001, 32'h0202_0202, 32'h7777_0002, 4'hC};
  localparam pay_t PG = {3'b110, 32'h0303_0303, 32'h7777_0003, 4'hD};
  localparam pay_t PH = {3'b011, 32'h0404_0404, 32'h7777_0004, 4'hE};
  localparam pay_t PJ = {3'b111, 32'h0505_0505, 32'h7777_0005, 4'hF};
  localparam pay_t PI = {3'b101, 32'h0606_0606, 32'h7777_0006, 4'h3};

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  ctrl_in;
  logic [31:0] alu_result_in, st_val_in;
  logic [3:0]  dest_in;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [2:0]  ctrl1, ctrl0;
  logic [31:0] alu1, st1, alu0, st0;
  logic [3:0]  dest1, dest0;
  logic [1:0]  occ1, occ0;

  pay_t q1[$];
  pay_t q0[$];
  logic acc1, acc0, lastRst, lastFlush;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exe_mem_pipe_reg #(.CTRL_W(3), .DATA_W(32), .DEST_W(4), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .ctrl_in(ctrl_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
    .out_valid(out_valid1), .out_ready(out_ready), .ctrl(ctrl1), .alu_result(alu1),
    .st_val(st1), .dest(dest1), .occupancy(occ1)
  );

  exe_mem_pipe_reg #(.CTRL_W(3), .DATA_W(32), .DEST_W(4), .SKID(0)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .ctrl_in(ctrl_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in), .dest_in(dest_in),
    .out_valid(out_valid0), .out_ready(out_ready), .ctrl(ctrl0), .alu_result(alu0),
    .st_val(st0), .dest(dest0), .occupancy(occ0)
  );

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int held, input logic expReady,
                             input pay_t front, input logic ov, input logic ir,
                             input logic [1:0] occ, input logic [2:0] c,
                             input logic [31:0] a, input logic [31:0] s, input logic [3:0] d);
    compare({tag, ".out_valid"}, 64'(ov), 64'(held > 0));
    compare({tag, ".occupancy"}, 64'(occ), 64'(held));
    compare({tag, ".in_ready"}, 64'(ir), 64'(expReady));
    if (held > 0) begin
      compare({tag, ".ctrl"}, 64'(c), 64'(front.c));
      compare({tag, ".alu_result"}, 64'(a), 64'(front.a));
      compare({tag, ".st_val"}, 64'(s), 64'(front.s));
      compare({tag, ".dest"}, 64'(d), 64'(front.d));
    end else begin
      compare({tag, ".bubble_ctrl"}, 64'(c), 64'h0);
    end
  endtask

  // Entries held by each DUT are the queued payloads minus any accepted this cycle.
  always @(negedge clk) begin : monitor
    int held1;
    int held0;
    if (rst === 1'b1) begin
      held1 = q1.size() - int'(acc1);
      checkOutput("skid", held1, held1 < 2, (held1 > 0) ? q1[0] : ZERO,
                  out_valid1, in_ready1, occ1, ctrl1, alu1, st1, dest1);
      if (held1 > 0 && out_ready) void'(q1.pop_front());
      held0 = q0.size() - int'(acc0);
      checkOutput("noskid", held0, (held0 == 0) || out_ready, (held0 > 0) ? q0[0] : ZERO,
                  out_valid0, in_ready0, occ0, ctrl0, alu0, st0, dest0);
      if (held0 > 0 && out_ready) void'(q0.pop_front());
    end
  end

  task automatic applyStimulus(input logic rstV, input logic flushV, input logic validV,
                               input pay_t p, input logic oreadyV);
    @(posedge clk);
    #1;
    if (!lastRst || lastFlush) begin
      q1.delete();
      q0.delete();
    end
    acc1          = 1'b0;
    acc0          = 1'b0;
    rst           = rstV;
    flush         = flushV;
    in_valid      = validV;
    ctrl_in       = p.c;
    alu_result_in = p.a;
    st_val_in     = p.s;
    dest_in       = p.d;
    out_ready     = oreadyV;
    #1;
    if (rstV && !flushV && validV) begin
      if (q1.size() < 2) begin
        q1.push_back(p);
        acc1 = 1'b1;
      end
      if (q0.size() == 0 || oreadyV) begin
        q0.push_back(p);
        acc0 = 1'b1;
      end
    end
    lastRst   = rstV;
    lastFlush = flushV;
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl_in = '0; alu_result_in = '0; st_val_in = '0; dest_in = '0;
    acc1 = 1'b0; acc0 = 1'b0; lastRst = 1'b0; lastFlush = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b0, ZERO, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, PJ, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);
    @(negedge clk);
    compare("reset.out_valid", 64'(out_valid1), 64'h0);
    compare("reset.in_ready", 64'(in_ready1), 64'h1);
    compare("reset.alu_result", 64'(alu1), 64'h0);
    compare("reset.st_val", 64'(st1), 64'h0);
    compare("reset.dest", 64'(dest1), 64'h0);
    compare("reset.noskid_in_ready", 64'(in_ready0), 64'h1);

    applyStimulus(1'b1, 1'b0, 1'b1, P1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);
    @(negedge clk);
    compare("stream.ctrl", 64'(ctrl1), 64'h5);
    compare("stream.alu_result", 64'(alu1), 64'h1234);
    compare("stream.dest", 64'(dest1), 64'hA);
    compare("stream.noskid_alu_result", 64'(alu0), 64'h1234);

    applyStimulus(1'b1, 1'b0, 1'b1, P2, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, P3, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, P4, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, PA, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, PB, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b0);
    @(negedge clk);
    compare("bp.occupancy", 64'(occ1), 64'h2);
    compare("bp.in_ready", 64'(in_ready1), 64'h0);
    compare("bp.hold_a", 64'(alu1), 64'(PA.a));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, PC, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, PD, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, PE, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);
    @(negedge clk);
    compare("flush.out_valid", 64'(out_valid1), 64'h0);
    compare("flush.ctrl", 64'(ctrl1), 64'h0);
    compare("flush.occupancy", 64'(occ1), 64'h0);
    compare("flush.noskid_out_valid", 64'(out_valid0), 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, PF, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, ZERO, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, PX, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, PY, 1'b1);
    @(negedge clk);
    compare("replace.in_ready", 64'(in_ready0), 64'h1);
    compare("replace.holds_x", 64'(dest0), 64'(PX.d));
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);
    @(negedge clk);
    compare("replace.out_valid", 64'(out_valid0), 64'h1);
    compare("replace.dest_y", 64'(dest0), 64'(PY.d));

    applyStimulus(1'b1, 1'b0, 1'b1, PG, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, PH, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, PJ, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, PI, 1'b0);
    @(negedge clk);
    compare("midrst.out_valid", 64'(out_valid1), 64'h0);
    compare("midrst.occupancy", 64'(occ1), 64'h0);
    compare("midrst.alu_result", 64'(alu1), 64'h0);
    compare("midrst.dest", 64'(dest1), 64'h0);
    compare("midrst.in_ready", 64'(in_ready1), 64'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);
    @(negedge clk);
    compare("midrst.fresh_valid", 64'(out_valid1), 64'h1);
    compare("midrst.fresh_alu", 64'(alu1), 64'(PI.a));
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, ZERO, 1'b1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
